fifo_reader: RTL and testbench

//  Read-side drain engine for the BRAM-backed fifo. Drives the fifo read port
//  (re/q/empty), absorbs the one-cycle SB_RAM40_4K read latency with a 2-entry

---
 rtl/fifo_reader.sv | 121 ++++++++++++
 tb/tb_fifo_reader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Read-side drain engine: issues fifo reads, absorbs the one-cycle BRAM latency in a
// 2-entry skid buffer and presents a valid/ready stream. Optional macro FIFO_READER_COUNT_EN adds rd_count.
module fifo_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  r_clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_re,
    input  logic [DATA_WIDTH-1:0] fifo_q,
    input  logic                  fifo_empty,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef FIFO_READER_COUNT_EN
    output logic [15:0]           rd_count,
`endif
    output logic                  busy
);

    logic [1:0]            cnt_r;
    logic                  inflight_r;
    logic [DATA_WIDTH-1:0] buf0_r;
    logic [DATA_WIDTH-1:0] buf1_r;
    logic                  m_valid_r;
    logic                  busy_r;

    logic                  pop_s;
    logic [2:0]            credit_s;
    logic [1:0]            cnt_nxt_s;
    logic [DATA_WIDTH-1:0] buf0_nxt_s;
    logic [DATA_WIDTH-1:0] buf1_nxt_s;

    assign pop_s    = m_valid_r & m_ready;
    // Occupancy after this cycle's capture and pop; never exceeds 2 because reads are credit-gated.
    assign credit_s = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign fifo_re  = en & ~fifo_empty & ~rst & (credit_s < 3'd2);

    assign cnt_nxt_s = credit_s[1:0];

    // Skid-buffer steering: where the captured word lands and whether buf1 shifts forward.
    always_comb begin
        buf0_nxt_s = buf0_r;
        buf1_nxt_s = buf1_r;
        case (cnt_r)
            2'd0: begin
                if (inflight_r) begin
                    buf0_nxt_s = fifo_q;
                end else begin
                    buf0_nxt_s = buf0_r;
                end
            end
            2'd1: begin
                if (inflight_r && pop_s) begin
                    buf0_nxt_s = fifo_q;
                end else if (inflight_r) begin
                    buf1_nxt_s = fifo_q;
                end else begin
                    buf0_nxt_s = buf0_r;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    buf0_nxt_s = buf1_r;
                    if (inflight_r) begin
                        buf1_nxt_s = fifo_q;
                    end else begin
                        buf1_nxt_s = buf1_r;
                    end
                end else begin
                    buf0_nxt_s = buf0_r;
                end
            end
            default: begin
                buf0_nxt_s = buf0_r;
                buf1_nxt_s = buf1_r;
            end
        endcase
    end

    // Buffer state and registered stream outputs.
    always_ff @(posedge r_clk) begin
        if (rst) begin
            cnt_r      <= 2'd0;
            inflight_r <= 1'b0;
            buf0_r     <= {DATA_WIDTH{1'b0}};
            buf1_r     <= {DATA_WIDTH{1'b0}};
            m_valid_r  <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            inflight_r <= fifo_re;
            buf0_r     <= buf0_nxt_s;
            buf1_r     <= buf1_nxt_s;
            m_valid_r  <= (cnt_nxt_s != 2'd0);
            busy_r     <= fifo_re | (cnt_nxt_s != 2'd0);
        end
    end

    assign m_data  = buf0_r;
    assign m_valid = m_valid_r;
    assign busy    = busy_r;

`ifdef FIFO_READER_COUNT_EN
    logic [15:0] rd_count_r;

    // Delivered-word counter, wraps naturally at 16 bits.
    always_ff @(posedge r_clk) begin
        if (rst) begin
            rd_count_r <= 16'd0;
        end else if (pop_s) begin
            rd_count_r <= rd_count_r + 16'd1;
        end else begin
            rd_count_r <= rd_count_r;
        end
    end

    assign rd_count = rd_count_r;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a behavioural fifo feeds the DUT, expected words are
// queued as they are written and a monitor compares every accepted output word.
module tb_fifo_reader;

    logic       r_clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fifo_re;
    logic [7:0] fifo_q;
    logic       fifo_empty;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       busy;
`ifdef FIFO_READER_COUNT_EN
    logic [15:0] rd_count;
`endif

    int passed = 0;
    int total  = 0;

    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         re_cnt = 0;
    int         viol   = 0;
    logic [7:0] exp_q [$];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    fifo_reader #(.DATA_WIDTH(8)) dut (
        .r_clk      (r_clk),
        .rst        (rst),
        .en         (en),
        .fifo_re    (fifo_re),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
`ifdef FIFO_READER_COUNT_EN
        .rd_count   (rd_count),
`endif
        .busy       (busy)
    );

    always #5 r_clk = ~r_clk;

    assign fifo_empty = (wr_ptr == rd_ptr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // Behavioural fifo with one-cycle read latency.
    always @(posedge r_clk) begin
        if (fifo_re) begin
            fifo_q <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
            re_cnt <= re_cnt + 1;
        end
    end

    // Monitor: sampled well before the next rising edge, after stimulus has settled.
    always @(negedge r_clk) begin
        #2;
        if (fifo_re && fifo_empty) viol++;
        if (prev_stall && m_valid) check("hold", {24'd0, m_data}, {24'd0, prev_data});
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
            end else begin
                check("data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
    end

    task automatic push(input logic [7:0] w);
        mem[wr_ptr] = w;
        exp_q.push_back(w);
        wr_ptr++;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 1000) begin
            @(negedge r_clk);
            n++;
        end
        @(negedge r_clk); #1;
        check({name, "_drained"}, exp_q.size(), 32'd0);
        check({name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    logic [15:0] pat;
    logic [7:0]  mv_exp;
    int          base;

    initial begin
        rst = 1'b1; en = 1'b0; m_ready = 1'b0;
        pat = 16'b1011_0010_1110_0101;
        mv_exp = 8'b0000_1110;
        repeat (2) @(negedge r_clk);
        #1;
        check("rst_fifo_re", {31'd0, fifo_re}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        rst = 1'b0;
        @(negedge r_clk);

        // 1: three words, full throughput, two-cycle latency
        en = 1'b1; m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        #1 check("t1_re_first", {31'd0, fifo_re}, 32'd1);
        for (int k = 1; k <= 5; k++) begin
            @(negedge r_clk); #1;
            check("t1_m_valid", {31'd0, m_valid}, {31'd0, mv_exp[k-1]});
        end
        check("t1_busy", {31'd0, busy}, 32'd0);

        // 2: backpressure holds two words and word0 stable
        @(negedge r_clk);
        m_ready = 1'b0;
        base = re_cnt;
        push(8'hA0); push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
        for (int k = 1; k <= 10; k++) begin
            @(negedge r_clk); #1;
            if (k >= 3) check("t2_head", {23'd0, m_valid, m_data}, {23'd0, 1'b1, 8'hA0});
        end
        check("t2_re_pulses", re_cnt - base, 32'd2);
        m_ready = 1'b1;
        drain("t2");

        // 3: 100 words with a toggling ready pattern
        for (int i = 0; i < 100; i++) push(8'(i * 7 + 3));
        for (int c = 0; c < 1000 && (exp_q.size() != 0 || busy); c++) begin
            m_ready = pat[c % 16];
            @(negedge r_clk);
        end
        m_ready = 1'b1;
        drain("t3");
        check("t3_no_empty_read", viol, 32'd0);

        // 4: dropping en stops new reads, in-flight words still arrive
        base = re_cnt;
        push(8'h51); push(8'h52); push(8'h53); push(8'h54); push(8'h55); push(8'h56);
        @(negedge r_clk);
        @(negedge r_clk);
        en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1 check("t4_re_off", {31'd0, fifo_re}, 32'd0);
            @(negedge r_clk);
        end
        check("t4_reads", re_cnt - base, 32'd2);
        check("t4_left", exp_q.size(), 32'd4);
        en = 1'b1;
        #1 check("t4_re_resume", {31'd0, fifo_re}, 32'd1);
        drain("t4");

        // 5: reset with a full buffer discards both buffered words
        m_ready = 1'b0;
        push(8'hC0); push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        repeat (6) @(negedge r_clk);
        rst = 1'b1;
        #1 check("t5_re_in_rst", {31'd0, fifo_re}, 32'd0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge r_clk); #1;
        check("t5_m_valid", {31'd0, m_valid}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_m_data", {24'd0, m_data}, 32'd0);
        rst = 1'b0;
        #1 check("t5_re_resume", {31'd0, fifo_re}, 32'd1);
        m_ready = 1'b1;
        drain("t5");

`ifdef FIFO_READER_COUNT_EN
        // 6: three words delivered since the last reset, then reset clears the count
        check("t6_count", {16'd0, rd_count}, 32'd3);
        rst = 1'b1;
        @(negedge r_clk); #1;
        check("t6_count_rst", {16'd0, rd_count}, 32'd0);
        rst = 1'b0;
`endif
        check("no_empty_read", viol, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
